// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Multiplexed 7-segment driver. Holds a sign+BCD word in a shadow register
//   and scans one digit at a time onto a shared active-low segment bus.
//   Decodes the sign nibble, optionally blanks leading zeros, and blinks the
//   whole display while the sign code reports overflow.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   BCD_IN    packed word: MS nibble = sign code, remaining nibbles = BCD
//             magnitude with digit 0 in the LS nibble
//   load      capture BCD_IN into the shadow register
//   lz_blank  1 = blank leading zeros of the magnitude
//   SEG       segments {g,f,e,d,c,b,a}, active-low, registered
//   AN        digit enables, one-hot active-low, bit k = digit k, registered
//   ovf       registered flag: shadow sign code is the overflow code (4'hb)

module bcd_display_scan #(
    parameter int DIGITS       = 6,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  ovf
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [3:0] SIGN_NEG = 4'ha;
    localparam logic [3:0] SIGN_OVF = 4'hb;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_ph;

    logic [3:0]          sign;
    logic [3:0]          nib;
    logic [DIGITS-2:0]   zero_above;
    logic                all_zero;
    logic [6:0]          seg_dec;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    assign sign = shadow[4*DIGITS-1 -: 4];
    assign nib  = shadow[4*idx +: 4];

    // Shadow capture, digit prescaler, scan index and blink timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= {4'hc, {(4*(DIGITS-1)){1'b0}}};
            presc     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (load)
                shadow <= BCD_IN;
            if (presc == PRE_LAST) begin
                presc <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    // Frame boundary: blink timing runs whatever the sign is.
                    if (blink_cnt == BLK_LAST) begin
                        blink_cnt <= '0;
                        blink_ph  <= ~blink_ph;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // zero_above[k] is set when magnitude digit k and every magnitude digit
    // above it are zero, i.e. digit k is a leading zero.
    always_comb begin
        zero_above = '0;
        all_zero   = 1'b1;
        for (int k = DIGITS - 2; k >= 0; k--) begin
            all_zero      = all_zero & (shadow[4*k +: 4] == 4'h0);
            zero_above[k] = all_zero;
        end
    end

    always_comb begin
        case (nib)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = SEG_OFF;
        endcase
    end

    always_comb begin
        seg_next = SEG_OFF;
        if (idx == IDX_LAST) begin
            case (sign)
                SIGN_NEG: seg_next = 7'b0111111;
                SIGN_OVF: seg_next = 7'b0000110;
                default:  seg_next = SEG_OFF;
            endcase
        end else if (lz_blank && (idx != '0) && zero_above[idx]) begin
            seg_next = SEG_OFF;
        end else begin
            seg_next = seg_dec;
        end
        // Blink blanks segments only; the digit enables keep scanning.
        if (sign == SIGN_OVF && blink_ph)
            seg_next = SEG_OFF;
    end

    assign an_next = ~(DIGITS'(1) << idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SEG <= SEG_OFF;
            AN  <= '1;
            ovf <= 1'b0;
        end else begin
            SEG <= seg_next;
            AN  <= an_next;
            ovf <= (sign == SIGN_OVF);
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    localparam int DIGITS       = 6;
    localparam int REFRESH_DIV  = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bcd_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b1;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // rising edges since reset release

    bcd_display_scan #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .BCD_IN   (bcd_in),
        .load     (load),
        .lz_blank (lz_blank),
        .SEG      (seg),
        .AN       (an),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        bcd_in = v;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Advance until the next edge starts a frame; ph >= 0 also requires that
    // frame's blink phase (phase flips every BLINK_FRAMES frames after reset).
    task automatic to_frame(input string tag, input int ph);
        int budget = 0;
        while (!((n % FRAME == 0) &&
                 (ph < 0 || ((n / FRAME) / BLINK_FRAMES) % 2 == ph)) && budget < 200) begin
            step();
            budget++;
        end
        if (budget >= 200) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // exp packs the six expected SEG values as {d5,d4,d3,d2,d1,d0}.
    task automatic check_frame(input string tag, input logic [41:0] exp, input int ph);
        logic [5:0] an_exp;
        to_frame(tag, ph);
        for (int d = 0; d < DIGITS; d++) begin
            step();
            step();
            an_exp = ~(6'd1 << d);
            check($sformatf("%s_an%0d", tag, d), 32'(an), 32'(an_exp));
            check($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(exp[7*d +: 7]));
            step();
            step();
        end
    endtask

    initial begin
        logic [5:0] an_seq [7];
        an_seq = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};

        #12;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'h3F);
        check("rst_ovf", 32'(ovf), 32'h0);

        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;

        for (int e = 1; e <= 25; e++) begin
            step();
            if ((e - 1) % 4 == 0)
                check($sformatf("scan_e%0d", e), 32'(an), 32'(an_seq[(e - 1) / 4]));
        end
        check("scan_hold", 32'(an), 32'h3E);

        lz_blank = 1'b1;
        do_load(24'hC00123);
        check_frame("c123_lz1", {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}, -1);
        lz_blank = 1'b0;
        check_frame("c123_lz0", {7'h7F, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, -1);

        lz_blank = 1'b1;
        do_load(24'hA00005);
        check_frame("a5", {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}, -1);
        do_load(24'hC00000);
        check_frame("c0", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, -1);

        do_load(24'hB99999);
        check("ovf_lag", 32'(ovf), 32'h0);
        step();
        check("ovf_set", 32'(ovf), 32'h1);
        check_frame("b9_on",  {7'h06, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}, 0);
        check_frame("b9_off", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1);
        check_frame("b9_on2", {7'h06, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}, 0);
        do_load(24'hC00001);
        step();
        check("ovf_clr", 32'(ovf), 32'h0);
        check_frame("c1_noblink", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}, 1);

        // Load while digit 2 is enabled.
        do_load(24'hC00123);
        to_frame("mid_sync", -1);
        while (n % FRAME != 9) step();
        check("mid_an_a",  32'(an),  32'h3B);
        check("mid_seg_a", 32'(seg), 32'h79);
        do_load(24'hC00456);
        check("mid_an_b",  32'(an),  32'h3B);
        check("mid_seg_b", 32'(seg), 32'h79);
        step();
        check("mid_an_c",  32'(an),  32'h3B);
        check("mid_seg_c", 32'(seg), 32'h19);
        step();
        check("mid_an_d",  32'(an),  32'h3B);

        // Asynchronous reset while digit 3 is enabled.
        lz_blank = 1'b0;
        while (n % FRAME != 14) step();
        check("pre_rst_an",  32'(an),  32'h37);
        check("pre_rst_seg", 32'(seg), 32'h40);
        #2 rst = 1'b1;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an",  32'(an),  32'h3F);
        check("arst_ovf", 32'(ovf), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        step();
        check("restart_an",  32'(an),  32'h3E);
        check("restart_seg", 32'(seg), 32'h40);
        check_frame("post_rst", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
